// File: rtl/himax_emu_pkg.sv
// Shared types for the Himax sensor emulator: FSM state encoding,
// pattern codes and a width helper for parameter-sized counters.
package himax_emu_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_VSYNC    = 3'd1,
    S_VFRONT   = 3'd2,
    S_LINE_ACT = 3'd3,
    S_LINE_BLK = 3'd4,
    S_VBACK    = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    PAT_COL = 2'd0,
    PAT_ROW = 2'd1,
    PAT_CHK = 2'd2,
    PAT_FRM = 2'd3
  } pat_e;

  // Bits needed to hold 0..n-1, never less than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/himax_emu_pattern.sv
// Pixel byte generator. Every pattern only looks at the low byte of its
// inputs, so the top hands over byte-wide views of col, row and frame count.
module himax_emu_pattern
  import himax_emu_pkg::*;
(
  input  logic [7:0] col,
  input  logic [7:0] row,
  input  logic [7:0] frame_cnt,
  input  pat_e       pattern,
  output logic [7:0] data
);

  // Select the byte for the current pixel from the latched pattern.
  always_comb begin
    data = 8'h00;
    unique case (pattern)
      PAT_COL: data = col;
      PAT_ROW: data = row;
      PAT_CHK: data = (col[3] ^ row[3]) ? 8'hFF : 8'h00;
      PAT_FRM: data = frame_cnt;
      default: data = 8'h00;
    endcase
  end

endmodule

// File: rtl/ice40_himax_sensor_emu.sv
// Himax-style camera timing emulator: vsync pulse, front porch, active
// lines with hsync, back porch. Outputs are registered from the next-state
// values so vsync, hsync and data change together on the same edge.
//
// state      | meaning
// -----------+--------------------------------------------------
// S_IDLE     | stopped, waiting for i_enable
// S_VSYNC    | vsync high for VS_WIDTH cycles
// S_VFRONT   | V_FRONT blank lines after vsync
// S_LINE_ACT | H_ACTIVE active pixels, hsync high
// S_LINE_BLK | H_BLANK blank cycles closing a line
// S_VBACK    | V_BACK blank lines, then restart or stop
//
// H_BLANK is assumed to be at least 1; V_FRONT and V_BACK may be zero.
module ice40_himax_sensor_emu
  import himax_emu_pkg::*;
#(
  parameter int H_ACTIVE = 324,
  parameter int H_BLANK  = 76,
  parameter int V_ACTIVE = 324,
  parameter int V_FRONT  = 4,
  parameter int V_BACK   = 8,
  parameter int VS_WIDTH = 16
) (
  input  logic        i_pclk_in,
  input  logic        resetn,
  input  logic        i_enable,
  input  logic [1:0]  i_pattern_sel,
  output logic        o_cam_vsync,
  output logic        o_cam_hsync,
  output logic [7:0]  o_cam_data,
  output logic [15:0] o_frame_cnt,
  output logic        o_busy
);

  localparam int H_TOTAL = H_ACTIVE + H_BLANK;
  localparam int COL_W   = clog2_min1(H_ACTIVE);
  localparam int ROW_W   = clog2_min1(V_ACTIVE);
  localparam int TMR_W   = clog2_min1(VS_WIDTH + (V_FRONT + V_BACK + 1) * H_TOTAL);

  localparam logic [TMR_W-1:0] VS_LOAD = TMR_W'(VS_WIDTH - 1);
  localparam logic [TMR_W-1:0] VF_LOAD = TMR_W'(V_FRONT * H_TOTAL - 1);
  localparam logic [TMR_W-1:0] HA_LOAD = TMR_W'(H_ACTIVE - 1);
  localparam logic [TMR_W-1:0] HB_LOAD = TMR_W'(H_BLANK - 1);
  localparam logic [TMR_W-1:0] VB_LOAD = TMR_W'(V_BACK * H_TOTAL - 1);
  localparam logic [TMR_W-1:0] TMR_ONE = TMR_W'(1);
  localparam logic [COL_W-1:0] COL_ONE = COL_W'(1);
  localparam logic [ROW_W-1:0] ROW_ONE = ROW_W'(1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(V_ACTIVE - 1);

  state_e             state_q, state_nxt;
  logic [TMR_W-1:0]   tmr_q, tmr_nxt;
  logic [COL_W-1:0]   col_q, col_nxt;
  logic [ROW_W-1:0]   row_q, row_nxt;
  pat_e               pat_q, pat_nxt;
  logic [15:0]        fcnt_q, fcnt_nxt;
  logic               start_frame;
  logic               vsync_d, hsync_d;
  logic [7:0]         data_d, pix_byte;

  // State, counters and registered outputs; reset aborts any frame at once.
  always_ff @(posedge i_pclk_in or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      tmr_q       <= '0;
      col_q       <= '0;
      row_q       <= '0;
      pat_q       <= PAT_COL;
      fcnt_q      <= '0;
      o_cam_vsync <= 1'b0;
      o_cam_hsync <= 1'b0;
      o_cam_data  <= 8'h00;
    end else begin
      state_q     <= state_nxt;
      tmr_q       <= tmr_nxt;
      col_q       <= col_nxt;
      row_q       <= row_nxt;
      pat_q       <= pat_nxt;
      fcnt_q      <= fcnt_nxt;
      o_cam_vsync <= vsync_d;
      o_cam_hsync <= hsync_d;
      o_cam_data  <= data_d;
    end
  end

  // Next state: down-counting timer per phase, terminal count moves on.
  always_comb begin
    state_nxt   = state_q;
    tmr_nxt     = tmr_q;
    col_nxt     = col_q;
    row_nxt     = row_q;
    pat_nxt     = pat_q;
    fcnt_nxt    = fcnt_q;
    start_frame = 1'b0;
    unique case (state_q)
      S_IDLE: start_frame = i_enable;
      S_VSYNC: begin
        if (tmr_q != '0) begin
          tmr_nxt = tmr_q - TMR_ONE;
        end else if (V_FRONT > 0) begin
          state_nxt = S_VFRONT;
          tmr_nxt   = VF_LOAD;
        end else begin
          state_nxt = S_LINE_ACT;
          tmr_nxt   = HA_LOAD;
          col_nxt   = '0;
        end
      end
      S_VFRONT: begin
        if (tmr_q != '0) begin
          tmr_nxt = tmr_q - TMR_ONE;
        end else begin
          state_nxt = S_LINE_ACT;
          tmr_nxt   = HA_LOAD;
          col_nxt   = '0;
        end
      end
      S_LINE_ACT: begin
        if (tmr_q != '0) begin
          tmr_nxt = tmr_q - TMR_ONE;
          col_nxt = col_q + COL_ONE;
        end else begin
          state_nxt = S_LINE_BLK;
          tmr_nxt   = HB_LOAD;
        end
      end
      S_LINE_BLK: begin
        if (tmr_q != '0) begin
          tmr_nxt = tmr_q - TMR_ONE;
        end else if (row_q != ROW_LAST) begin
          state_nxt = S_LINE_ACT;
          tmr_nxt   = HA_LOAD;
          col_nxt   = '0;
          row_nxt   = row_q + ROW_ONE;
        end else if (V_BACK > 0) begin
          state_nxt = S_VBACK;
          tmr_nxt   = VB_LOAD;
        end else if (i_enable) begin
          start_frame = 1'b1;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_VBACK: begin
        if (tmr_q != '0) begin
          tmr_nxt = tmr_q - TMR_ONE;
        end else if (i_enable) begin
          start_frame = 1'b1;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    if (start_frame) begin
      state_nxt = S_VSYNC;
      tmr_nxt   = VS_LOAD;
      col_nxt   = '0;
      row_nxt   = '0;
      pat_nxt   = pat_e'(i_pattern_sel);
      fcnt_nxt  = fcnt_q + 16'd1;
    end
  end

  himax_emu_pattern u_pattern (
    .col       (8'(col_nxt)),
    .row       (8'(row_nxt)),
    .frame_cnt (fcnt_nxt[7:0]),
    .pattern   (pat_nxt),
    .data      (pix_byte)
  );

  // Output decode from next state so the registered outputs line up with it.
  always_comb begin
    vsync_d = (state_nxt == S_VSYNC);
    hsync_d = (state_nxt == S_LINE_ACT);
    data_d  = hsync_d ? pix_byte : 8'h00;
  end

  assign o_frame_cnt = fcnt_q;
  assign o_busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_ice40_himax_sensor_emu.sv
// Bench for the sensor emulator: frame-position reference model compared
// every cycle, directed scenarios with literal expectations, random run.
module tb_ice40_himax_sensor_emu;

  localparam int HA = 4;
  localparam int HB = 2;
  localparam int VA = 3;
  localparam int VF = 1;
  localparam int VB = 1;
  localparam int VS = 2;
  localparam int HT = HA + HB;
  localparam int PERIOD = VS + (VF + VA + VB) * HT;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        en = 1'b0;
  logic [1:0]  sel = 2'd0;
  logic        vsync, hsync, busy;
  logic [7:0]  data;
  logic [15:0] fcnt;

  int checks = 0;
  int failures = 0;
  logic chk_on = 1'b1;
  logic poke = 1'b0;

  always #5 clk = ~clk;

  ice40_himax_sensor_emu #(
    .H_ACTIVE (HA), .H_BLANK (HB), .V_ACTIVE (VA),
    .V_FRONT  (VF), .V_BACK  (VB), .VS_WIDTH (VS)
  ) dut (
    .i_pclk_in     (clk),
    .resetn        (resetn),
    .i_enable      (en),
    .i_pattern_sel (sel),
    .o_cam_vsync   (vsync),
    .o_cam_hsync   (hsync),
    .o_cam_data    (data),
    .o_frame_cnt   (fcnt),
    .o_busy        (busy)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: only tracks idle/running, position within the frame,
  // the frame count and the pattern captured at frame start.
  logic        m_idle = 1'b1;
  int          m_p = 0;
  logic [15:0] m_fcnt = 16'd0;
  logic [1:0]  m_pat = 2'd0;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_idle <= 1'b1;
      m_p    <= 0;
      m_fcnt <= 16'd0;
      m_pat  <= 2'd0;
    end else if (m_idle || m_p == PERIOD - 1) begin
      if (en) begin
        m_idle <= 1'b0;
        m_p    <= 0;
        m_fcnt <= m_fcnt + 16'd1;
        m_pat  <= sel;
      end else begin
        m_idle <= 1'b1;
        m_p    <= 0;
        if (poke) m_fcnt <= 16'hFFFF;
      end
    end else begin
      m_p <= m_p + 1;
    end
  end

  int q, r, c;
  logic e_vs, e_hs;
  logic [7:0] e_d;
  always_comb begin
    q = m_p - VS - VF * HT;
    r = 0;
    c = 0;
    e_vs = 1'b0;
    e_hs = 1'b0;
    e_d = 8'h00;
    if (!m_idle) begin
      e_vs = (m_p < VS);
      if (q >= 0 && q < VA * HT && (q % HT) < HA) begin
        e_hs = 1'b1;
        r = q / HT;
        c = q % HT;
        case (m_pat)
          2'd0: e_d = 8'(c);
          2'd1: e_d = 8'(r);
          2'd2: e_d = (((c / 8) % 2) != ((r / 8) % 2)) ? 8'hFF : 8'h00;
          default: e_d = m_fcnt[7:0];
        endcase
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (resetn && chk_on) begin
      chk("m_vsync", 32'(vsync), 32'(e_vs));
      chk("m_hsync", 32'(hsync), 32'(e_hs));
      chk("m_data",  32'(data),  32'(e_d));
      chk("m_fcnt",  32'(fcnt),  32'(m_fcnt));
      chk("m_busy",  32'(busy),  32'(!m_idle));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  logic       vs_a [96];
  logic       hs_a [96];
  logic [7:0] d_a  [96];
  logic [15:0] f_a [96];

  initial begin
    int n_vs, n_hs, n_rise, n_late;
    logic got_idle;
    repeat (3) tick();
    chk("rst_vsync", 32'(vsync), 32'd0);
    chk("rst_hsync", 32'(hsync), 32'd0);
    chk("rst_data",  32'(data),  32'd0);
    chk("rst_fcnt",  32'(fcnt),  32'd0);
    chk("rst_busy",  32'(busy),  32'd0);
    resetn = 1'b1;
    tick();
    chk("idle_busy", 32'(busy), 32'd0);

    // Free-running column ramp, three frames.
    sel = 2'd0;
    en = 1'b1;
    for (int i = 0; i < 96; i++) begin
      tick();
      vs_a[i] = vsync; hs_a[i] = hsync; d_a[i] = data; f_a[i] = fcnt;
    end
    n_vs = 0; n_hs = 0; n_rise = 0;
    for (int i = 0; i < 96; i++) begin
      if (vs_a[i]) n_vs++;
      if (hs_a[i]) n_hs++;
      if (hs_a[i] && (i == 0 || !hs_a[i-1])) n_rise++;
    end
    chk("a_vs0", 32'(vs_a[0]), 32'd1);
    chk("a_vs1", 32'(vs_a[1]), 32'd1);
    chk("a_vs2", 32'(vs_a[2]), 32'd0);
    chk("a_vs32", 32'(vs_a[32]), 32'd1);
    chk("a_vs64", 32'(vs_a[64]), 32'd1);
    chk("a_vs_cycles", 32'(n_vs), 32'd6);
    chk("a_hs_cycles", 32'(n_hs), 32'd36);
    chk("a_hs_pulses", 32'(n_rise), 32'd9);
    for (int k = 0; k < 3; k++)
      for (int cc = 0; cc < 4; cc++)
        chk("a_ramp", 32'(d_a[8 + 6*k + cc]), 32'(cc));
    chk("a_blank", 32'(d_a[12]), 32'd0);
    chk("a_f1", 32'(f_a[0]), 32'd1);
    chk("a_f2", 32'(f_a[32]), 32'd2);
    chk("a_f3", 32'(f_a[64]), 32'd3);

    // Row pattern for the fourth frame.
    sel = 2'd1;
    for (int p = 0; p < 32; p++) begin
      tick();
      if (p >= 8 && p < 26) begin
        if (((p - 8) % 6) < 4) chk("b_row", 32'(data), 32'((p - 8) / 6));
        else chk("b_blank", 32'(data), 32'd0);
      end
    end

    // Enable dropped at cycle 10: frame must still run to the end.
    sel = 2'd0;
    for (int p = 0; p < 32; p++) begin
      tick();
      if (p == 10) en = 1'b0;
      if (p == 31) chk("e_busy_end", 32'(busy), 32'd1);
    end
    tick();
    chk("e_busy_idle", 32'(busy), 32'd0);
    n_late = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (vsync) n_late++;
    end
    chk("e_no_vsync", 32'(n_late), 32'd0);

    // Reset in the middle of an active line.
    en = 1'b1;
    for (int p = 0; p < 10; p++) tick();
    chk("d_in_line", 32'(hsync), 32'd1);
    #3 resetn = 1'b0;
    #1;
    chk("d_rst_vsync", 32'(vsync), 32'd0);
    chk("d_rst_hsync", 32'(hsync), 32'd0);
    chk("d_rst_data",  32'(data),  32'd0);
    chk("d_rst_fcnt",  32'(fcnt),  32'd0);
    chk("d_rst_busy",  32'(busy),  32'd0);
    #2 resetn = 1'b1;
    tick();
    chk("d_vsync_first", 32'(vsync), 32'd1);
    chk("d_fcnt_first", 32'(fcnt), 32'd1);

    // Pattern select moved to frame-count mid-frame.
    for (int p = 1; p < 32; p++) begin
      tick();
      if (p == 10) sel = 2'd3;
      if (p == 15) chk("c_cur_ramp", 32'(data), 32'd1);
    end
    for (int p = 0; p < 32; p++) begin
      tick();
      if (p == 0) chk("c_fcnt2", 32'(fcnt), 32'd2);
      if (p >= 8 && p < 26 && ((p - 8) % 6) < 4) chk("c_next_frm", 32'(data), 32'h02);
    end

    // Frame counter wrap.
    en = 1'b0;
    got_idle = 1'b0;
    for (int i = 0; i < 100 && !got_idle; i++) begin
      tick();
      if (!busy) got_idle = 1'b1;
    end
    chk("f_idle_reached", 32'(got_idle), 32'd1);
    chk_on = 1'b0;
    force dut.fcnt_q = 16'hFFFF;
    poke = 1'b1;
    tick();
    release dut.fcnt_q;
    poke = 1'b0;
    chk_on = 1'b1;
    chk("f_preset", 32'(fcnt), 32'hFFFF);
    en = 1'b1;
    tick();
    chk("f_wrap", 32'(fcnt), 32'h0000);
    chk("f_wrap_vsync", 32'(vsync), 32'd1);

    // Random enable and pattern traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 7) == 0) sel = 2'($urandom_range(0, 3));
      tick();
    end

    en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ice40_himax_sensor_emu.md
ICE40_HIMAX_SENSOR_EMU -- requirements
Module: ice40_himax_sensor_emu

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 324: active pixels per line.
REQ-002 SHALL have parameter H_BLANK, default 76: blank cycles per line; H_TOTAL = H_ACTIVE + H_BLANK.
REQ-003 SHALL have parameter V_ACTIVE, default 324: active lines per frame.
REQ-004 SHALL have parameters V_FRONT, default 4, and V_BACK, default 8: blank lines after vsync and before the next vsync.
REQ-005 SHALL have parameter VS_WIDTH, default 16: vsync high time in pclk cycles.
REQ-006 SHALL have port i_pclk_in  input  1  pixel clock; all logic is clocked on its rising edge.
REQ-007 SHALL have port resetn  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have port i_enable  input  1  run request, sampled only at frame boundaries.
REQ-009 SHALL have port i_pattern_sel  input  2  pattern select, latched at frame start.
REQ-010 SHALL have port o_cam_vsync  output  1  frame sync, active-high pulse at frame start.
REQ-011 SHALL have port o_cam_hsync  output  1  line valid, high during active pixels.
REQ-012 SHALL have port o_cam_data  output  8  pixel byte.
REQ-013 SHALL have port o_frame_cnt  output  16  frames started since reset.
REQ-014 SHALL have port o_busy  output  1  high whenever the FSM is not in S_IDLE.

Function
REQ-015 SHALL implement FSM states S_IDLE, S_VSYNC, S_VFRONT, S_LINE_ACT, S_LINE_BLK, S_VBACK.
REQ-016 S_IDLE -> S_VSYNC on the first edge with i_enable = 1; at that same edge o_cam_vsync goes high, i_pattern_sel is latched, and o_frame_cnt increments (wrapping 0xFFFF -> 0x0000).
REQ-017 S_VSYNC SHALL last exactly VS_WIDTH cycles with o_cam_vsync = 1, then go to S_VFRONT.
REQ-018 S_VFRONT SHALL last V_FRONT*H_TOTAL cycles; if V_FRONT = 0 it is skipped.
REQ-019 Each active line SHALL be H_ACTIVE cycles in S_LINE_ACT (o_cam_hsync = 1) followed by H_BLANK cycles in S_LINE_BLK (o_cam_hsync = 0), repeated V_ACTIVE times.
REQ-020 S_VBACK SHALL last V_BACK*H_TOTAL cycles, then exit as follows.
REQ-021 On S_VBACK exit: if i_enable = 1, go directly to S_VSYNC, which restarts the frame actions of REQ-016 with no gap; otherwise go to S_IDLE.
REQ-022 Frame period SHALL be exactly VS_WIDTH + (V_FRONT + V_ACTIVE + V_BACK)*H_TOTAL cycles while enabled.
REQ-023 Deasserting i_enable mid-frame SHALL NOT truncate the frame.
REQ-024 Column counter col (0..H_ACTIVE-1) and row counter row (0..V_ACTIVE-1) SHALL be sized by clog2 of their parameter and SHALL never exceed their range.
REQ-025 Pattern 0: data = col[7:0].
REQ-026 Pattern 1: data = row[7:0].
REQ-027 Pattern 2: data = 8'hFF if col[3]^row[3], else 8'h00.
REQ-028 Pattern 3: data = o_frame_cnt[7:0].
REQ-029 o_cam_data SHALL be 8'h00 whenever o_cam_hsync = 0.
REQ-030 o_cam_vsync, o_cam_hsync and o_cam_data SHALL all be registered and mutually aligned (same cycle); there is no combinational path from input to output.
REQ-031 A change on i_pattern_sel mid-frame SHALL take effect only at the next frame start.

Reset
REQ-032 resetn low SHALL force S_IDLE and the following values: o_cam_vsync = 0, o_cam_hsync = 0, o_cam_data = 0, o_frame_cnt = 0, o_busy = 0, col = 0, row = 0, latched pattern = 0.
REQ-033 Reset asserted mid-frame SHALL abort the frame immediately; after release, the first frame SHALL start only per REQ-016.

Structure
REQ-034 Package himax_emu_pkg SHALL hold the FSM state encoding and the pattern-code constants (PAT_COL, PAT_ROW, PAT_CHK, PAT_FRM).
REQ-035 Pixel-byte selection SHALL be one sub-module, himax_emu_pattern, with inputs col, row, frame count and latched pattern, and output the data byte.

Verification
REQ-036 Bench SHALL use small parameters H_ACTIVE=4, H_BLANK=2, V_ACTIVE=3, V_FRONT=1, V_BACK=1, VS_WIDTH=2; frame period is then 32 cycles.
REQ-037 Scenario: enable held high, pattern 0 -> vsync high 2 cycles every 32 cycles; 3 hsync pulses per frame, each 4 cycles wide; data 0,1,2,3 on each line; frame_cnt 1,2,3.
REQ-038 Scenario: pattern 1 -> data 0,0,0,0 / 1,1,1,1 / 2,2,2,2 on the three lines; data 0 during blanking.
REQ-039 Scenario: i_enable dropped at cycle 10 of frame 1 -> frame completes all 32 cycles, FSM enters S_IDLE, o_busy = 0, no further vsync.
REQ-040 Scenario: i_pattern_sel changed 0->3 mid-frame -> current frame stays a column ramp; next frame data equals 8'h02 on every active pixel.
REQ-041 Scenario: resetn pulsed low during S_LINE_ACT -> all outputs are 0 immediately; with enable high, vsync rises on the first edge after release; frame_cnt restarts at 1.
REQ-042 Scenario: o_frame_cnt forced to 0xFFFF -> next frame start yields 0x0000.
